shift_right_32_pipe: RTL and testbench

Three-stage pipelined 32-bit right barrel shifter that executes RV32 SRL/SRLI and SRA/SRAI in the EX path, complementing the existing combinational left shifter. Each operand pair enters with a destination tag, is shifted through five log-levels (1, 2, 4, 8 and 16 bits) split across three register stages, and leaves on a valid/ready output with its tag. It sustains one result per cycle, stalls on back-pressure without losing data, and supports a pipeline flush.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_right_level.sv | 15 +
 rtl/shift_right_32_pipe.sv | 90 +++++++++
 tb/tb_shift_right_32_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, shift-mode encodings and stage payloads for the right shifter
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_mode_e;

  // S1 still owes shift bits [4:2]; S2 only owes bit 4.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [2:0]      shamt;
    logic            fill;
  } s1_pl_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            shamt;
    logic            fill;
  } s2_pl_t;

endpackage

// File: rtl/shift_right_level.sv
// rtl/shift_right_level.sv - one log-level of a right shift by SH with an explicit fill bit
module shift_right_level
  import shift_pkg::*;
#(
  parameter int SH = 1
) (
  input  logic [XLEN-1:0] din,
  input  logic            en,
  input  logic            fill,
  output logic [XLEN-1:0] dout
);

  assign dout = en ? {{SH{fill}}, din[XLEN-1:SH]} : din;

endmodule

// File: rtl/shift_right_32_pipe.sv
// rtl/shift_right_32_pipe.sv - three-stage SRL/SRA barrel shifter with valid/ready and flush
module shift_right_32_pipe
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    data1,
  input  logic [SHAMT_W-1:0] data2,
  input  logic               arith,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic [TAG_W-1:0]   out_tag
);

  s1_pl_t           s1;
  s2_pl_t           s2;
  logic             s1_valid, s2_valid;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  logic            in_fill;
  logic [XLEN-1:0] l1, l2, l4, l8, l16;
  logic            s1_load, s2_load, s3_load;

  assign in_fill = (shift_mode_e'(arith) == SHIFT_ARITH) & data1[XLEN-1];

  shift_right_level #(.SH(1))  u_l1  (.din(data1),   .en(data2[0]),   .fill(in_fill), .dout(l1));
  shift_right_level #(.SH(2))  u_l2  (.din(l1),      .en(data2[1]),   .fill(in_fill), .dout(l2));
  shift_right_level #(.SH(4))  u_l4  (.din(s1.data), .en(s1.shamt[0]), .fill(s1.fill), .dout(l4));
  shift_right_level #(.SH(8))  u_l8  (.din(l4),      .en(s1.shamt[1]), .fill(s1.fill), .dout(l8));
  shift_right_level #(.SH(16)) u_l16 (.din(s2.data), .en(s2.shamt),    .fill(s2.fill), .dout(l16));

  // A stage may load when empty or when its contents move on this edge;
  // this chains combinationally from out_ready back to in_ready.
  assign s3_load  = !out_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !flush && s1_load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1        <= '0;
      s2        <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.data  <= l2;
          s1.shamt <= data2[4:2];
          s1.fill  <= in_fill;
          s1_tag   <= in_tag;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2.data  <= l8;
          s2.shamt <= s1.shamt[2];
          s2.fill  <= s1.fill;
          s2_tag   <= s1_tag;
        end
      end
      if (s3_load) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          result  <= l16;
          out_tag <= s2_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_right_32_pipe.sv
// tb/tb_shift_right_32_pipe.sv - scoreboard bench for the pipelined right shifter
module tb_shift_right_32_pipe;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, arith, out_valid, out_ready;
  logic [31:0] data1, result;
  logic [4:0]  data2, in_tag, out_tag;

  always #5 clk = ~clk;

  shift_right_32_pipe #(.TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .arith(arith), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   npop = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sr(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    ref_sr = a ? 32'(sd >>> s) : (d >> s);
  endfunction

  task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] s, input logic a,
                       input logic [4:0] t, input logic ordy, input logic fl, input logic rn);
    exp_t e;
    in_valid = v; data1 = d; data2 = s; arith = a; in_tag = t;
    out_ready = ordy; flush = fl; resetn = rn;
    @(negedge clk);
    if (out_valid && out_ready && resetn && !flush) begin
      if (sbq.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("tag", out_tag, e.tag);
        if (lat_chk) check("latency", cyc - e.acc, 3);
        npop++;
      end
    end
    if (in_valid && in_ready && resetn) begin
      e.res = ref_sr(d, s, a); e.tag = t; e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rn || fl) sbq.delete();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, ordy, 1'b0, 1'b1);
  endtask

  task automatic rnd_op(input logic ordy);
    cycle(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), ordy, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    resetn = 1'b1; flush = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed SRL / SRA cases with latency checking.
    lat_chk = 1'b1;
    cycle(1'b1, 32'h8000_0000, 5'd31, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    cycle(1'b1, 32'h8000_0000, 5'd31, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hF000_00F0, 5'd4,  1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hF000_00F0, 5'd0,  1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h8765_4321, 5'd0,  1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h7FFF_FFFF, 5'd16, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    check("directed_count", npop, 6);

    // Back-to-back stream: latency 3 on every op implies consecutive outputs.
    n0 = npop;
    for (int i = 0; i < 10; i++) rnd_op(1'b1);
    idle(5, 1'b1);
    check("stream_count", npop - n0, 10);
    check("stream_drained", sbq.size(), 0);

    // Back-pressure on a full pipe.
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) rnd_op(1'b0);
    check("bp_occupancy", sbq.size(), 3);
    for (int i = 0; i < 4; i++) begin
      rnd_op(1'b0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result_hold", result, sbq[0].res);
      check("bp_tag_hold", out_tag, sbq[0].tag);
    end
    n0 = npop;
    idle(6, 1'b1);
    check("bp_drain_count", npop - n0, 3);
    check("bp_drained", sbq.size(), 0);

    // Flush with two ops in flight and a live input.
    cycle(1'b1, 32'h1234_5678, 5'd3, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h9234_5678, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("flush_out_valid", out_valid, 0);
      idle(1, 1'b1);
    end
    idle(3, 1'b1);
    check("flush_empty", sbq.size(), 0);

    // Reset while three ops are in flight.
    for (int i = 0; i < 3; i++) rnd_op(1'b0);
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_result", result, 0);
    check("mrst_out_tag", out_tag, 0);
    check("mrst_in_ready", in_ready, 1);
    idle(5, 1'b1);

    // Bubble compression: S3 full and stalled, S1/S2 still accept.
    cycle(1'b1, 32'hC000_0000, 5'd2, 1'b1, 5'd20, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    check("bub_out_valid", out_valid, 1);
    check("bub_in_ready0", in_ready, 1);
    rnd_op(1'b0);
    check("bub_in_ready1", in_ready, 1);
    rnd_op(1'b0);
    check("bub_occupancy", sbq.size(), 3);
    n0 = npop;
    idle(6, 1'b1);
    check("bub_drain_count", npop - n0, 3);

    check("final_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
